booth_div: RTL and testbench

- Sequential signed integer divider; the inverse-operation companion to the Booth multiplier in the arithmetic datapath.
- Uses the same handshake style as the multiplier: level `en` request, `busy` status, registered results.
- Restoring radix-2 algorithm on operand magnitudes, one quotient bit per clock, sign fix-up at the end.
- Produces quotient truncated toward zero and remainder carrying the dividend's sign (C semantics).

---
 rtl/booth_div.sv | 150 +++++++++++++++
 tb/tb_booth_div.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/booth_div.sv
// Sequential signed divider: restoring radix-2 on operand magnitudes, one quotient
// bit per clock, sign fix-up on the completing edge (C truncating semantics).
module booth_div #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R,
  output logic             dbz,
  output logic [1:0]       dbg_state
);

  // Handshake: en is a level request, accepted on a rising edge only while idle
  // and armed; busy is high from the accepting edge until the completing edge,
  // where Q/R/dbz update. A request must see en low on some edge before the
  // next acceptance, so en held high across completion never retriggers.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2,
    S_ZERO = 2'd3
  } state_t;

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  state_t           state_q, state_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             sgnq_q, sgnq_d;
  logic             sgnr_q, sgnr_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dbz_q, dbz_d;

  logic             accept;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   rem_sh, diff;
  logic             ge;

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    a_d     = a_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;

    accept = (state_q == S_IDLE) && en && armed_q;
    // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is exact as an unsigned value.
    abs_a  = A[WIDTH-1] ? (~A + ONE) : A;
    abs_b  = B[WIDTH-1] ? (~B + ONE) : B;
    // Trial subtract is one bit wider; its top bit is the borrow.
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    ge     = ~diff[WIDTH];

    if (!en) armed_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          armed_d = 1'b0;
          a_d     = A;
          sgnq_d  = A[WIDTH-1] ^ B[WIDTH-1];
          sgnr_d  = A[WIDTH-1];
          quo_d   = abs_a;
          dvs_d   = abs_b;
          rem_d   = '0;
          cnt_d   = CNT_INIT;
          state_d = (B == '0) ? S_ZERO : S_CALC;
        end
      end
      S_CALC: begin
        rem_d = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ge};
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_SIGN;
      end
      S_SIGN: begin
        q_d     = sgnq_q ? -quo_q : quo_q;
        r_d     = sgnr_q ? -rem_q : rem_q;
        dbz_d   = 1'b0;
        state_d = S_IDLE;
      end
      S_ZERO: begin
        q_d     = '1;
        r_d     = a_q;
        dbz_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      armed_q <= 1'b1;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      a_q     <= '0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      a_q     <= a_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign Q         = q_q;
  assign R         = r_q;
  assign dbz       = dbz_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_booth_div.sv
// Bench for booth_div: directed vector table, randomized ops against a plain
// arithmetic reference, and hand-written re-arm / async-reset sequences.
module tb_booth_div;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en  = 1'b0;
  logic [W-1:0] A   = '0;
  logic [W-1:0] B   = '0;
  logic         busy;
  logic [W-1:0] Q, R;
  logic         dbz;
  logic [1:0]   dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*W:0] exp_q[$];

  booth_div #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .A         (A),
    .B         (B),
    .busy      (busy),
    .Q         (Q),
    .R         (R),
    .dbz       (dbz),
    .dbg_state (dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference: C-style truncating division on wide signed integers.
  function automatic logic [2*W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, q, r;
    if (b == '0) return {{W{1'b1}}, a, 1'b1};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa % sb;
    return {q[W-1:0], r[W-1:0], 1'b0};
  endfunction

  // Driver: start one op, scramble A/B while busy, count busy cycles, score result.
  task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                       input int exp_busy, input bit hold_en, input logic [2*W:0] exp);
    int cnt;
    int guard;
    logic [2*W:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    A  = a;
    B  = b;
    en = 1'b1;
    cnt   = 0;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
      if (busy) cnt++;
      if (guard == 2 && !hold_en) en = 1'b0;
      A = W'($urandom);
      B = W'($urandom);
    end while (busy && guard < 200);
    if (!hold_en) en = 1'b0;
    check({name, "_busy_cycles"}, 32'(cnt), 32'(exp_busy));
    e = exp_q.pop_front();
    check({name, "_q"},   {16'h0, Q}, {16'h0, e[2*W:W+1]});
    check({name, "_r"},   {16'h0, R}, {16'h0, e[W:1]});
    check({name, "_dbz"}, {31'h0, dbz}, {31'h0, e[0]});
  endtask

  initial begin
    int seen;
    logic [W-1:0] ra, rb;

    vecs[0] = '{16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0, 17};
    vecs[1] = '{16'hFF9C, 16'd7,    16'hFFF2, 16'hFFFE, 1'b0, 17};
    vecs[2] = '{16'd100,  16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 17};
    vecs[3] = '{16'hFF9C, 16'hFFF9, 16'h000E, 16'hFFFE, 1'b0, 17};
    vecs[4] = '{16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 17};
    vecs[5] = '{16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 17};
    vecs[6] = '{16'd3,    16'd5,    16'h0000, 16'h0003, 1'b0, 17};
    vecs[7] = '{16'd5,    16'd0,    16'hFFFF, 16'h0005, 1'b1, 1};
    vecs[8] = '{16'd9,    16'd3,    16'h0003, 16'h0000, 1'b0, 17};
    vecs[9] = '{16'd0,    16'hFFFB, 16'h0000, 16'h0000, 1'b0, 17};

    // Reset state
    #12;
    check("rst_busy",  {31'h0, busy}, 32'h0);
    check("rst_q",     {16'h0, Q}, 32'h0);
    check("rst_r",     {16'h0, R}, 32'h0);
    check("rst_dbz",   {31'h0, dbz}, 32'h0);
    check("rst_state", {30'h0, dbg_state}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Directed vector table
    for (int i = 0; i < 10; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].lat, 1'b0,
            {vecs[i].q, vecs[i].r, vecs[i].dbz});

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      if (i % 10 == 3) rb = W'($urandom_range(1, 3));
      do_op($sformatf("rnd%0d", i), ra, rb, (rb == '0) ? 1 : 17, 1'b0, model(ra, rb));
    end

    // En held high across completion must not retrigger
    do_op("hold", 16'd100, 16'd7, 17, 1'b1, model(16'd100, 16'd7));
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy) seen++;
    end
    check("no_retrigger", 32'(seen), 32'h0);
    en = 1'b0;
    do_op("rearm", 16'd9, 16'd3, 17, 1'b0, {16'h0003, 16'h0000, 1'b0});

    // Async reset mid-operation, between clock edges
    @(negedge clk);
    A  = 16'd100;
    B  = 16'd7;
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 1) en = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_q",    {16'h0, Q}, 32'h0);
    check("midrst_r",    {16'h0, R}, 32'h0);
    check("midrst_dbz",  {31'h0, dbz}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    do_op("post_rst", 16'd100, 16'd7, 17, 1'b0, {16'h000E, 16'h0002, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
